regfile_sb: RTL

Parametrised integer register file with N combinational read ports, two prioritised write ports, a per-register busy scoreboard and an outstanding-write counter. It sits between decode/issue (reads operands, marks destinations pending) and the writeback stage (ALU and load results). Optionally, same-cycle writeback data is forwarded to the read ports.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/regfile_sb.sv | 93 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the regfile_sb register file slice.
package rf_pkg;

   localparam int RF_ADDR_W    = 5;
   localparam int RF_DATA_W    = 32;
   localparam int RF_NUM_READ  = 2;
   localparam int RF_MAX_DEPTH = 256;

   // Callers zero-extend their busy vector to RF_MAX_DEPTH bits (ADDR_WIDTH up to 8).
   function automatic int unsigned popcount(input logic [RF_MAX_DEPTH-1:0] vec);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < RF_MAX_DEPTH; i++) begin
         if (vec[i]) cnt++;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: issue sets a bit, writeback clears it, issue wins a same-cycle tie.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter bit ZERO_REG   = 1'b1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_issValid,
   input  logic [ADDR_WIDTH-1:0]      i_issRd,
   input  logic                       i_w0En,
   input  logic [ADDR_WIDTH-1:0]      i_w0Addr,
   input  logic                       i_w1En,
   input  logic [ADDR_WIDTH-1:0]      i_w1Addr,
   output logic [2**ADDR_WIDTH-1:0]   o_busy,
   output logic [ADDR_WIDTH:0]        o_pendCnt
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_set;
   logic [DEPTH-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (i_issValid) w_set[i_issRd] = 1'b1;
      if (i_w0En)     w_clr[i_w0Addr] = 1'b1;
      if (i_w1En)     w_clr[i_w1Addr] = 1'b1;
      if (ZERO_REG)   w_set[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_set | (r_busy & ~w_clr);
      end
   end

   // Derived straight from the busy bits so it tracks them exactly, including on async reset.
   assign o_busy    = r_busy;
   assign o_pendCnt = CNT_W'(popcount(RF_MAX_DEPTH'(r_busy)));

endmodule

// File: rtl/regfile_sb.sv
// Register file with N read ports, two prioritised write ports and a busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
   import rf_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int NUM_READ   = RF_NUM_READ,
   parameter bit ZERO_REG   = 1'b1
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
   output logic [NUM_READ-1:0]            rbusy,
   input  logic                           iss_valid,
   input  logic [ADDR_WIDTH-1:0]          iss_rd,
   input  logic                           w0_en,
   input  logic [ADDR_WIDTH-1:0]          w0_addr,
   input  logic [DATA_WIDTH-1:0]          w0_data,
   input  logic                           w1_en,
   input  logic [ADDR_WIDTH-1:0]          w1_addr,
   input  logic [DATA_WIDTH-1:0]          w1_data,
   output logic [ADDR_WIDTH:0]            pend_cnt,
   output logic [DATA_WIDTH-1:0]          reg0
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      w_busy;

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_issValid (iss_valid),
      .i_issRd    (iss_rd),
      .i_w0En     (w0_en),
      .i_w0Addr   (w0_addr),
      .i_w1En     (w1_en),
      .i_w1Addr   (w1_addr),
      .o_busy     (w_busy),
      .o_pendCnt  (pend_cnt)
   );

   // w1 (LSU) is checked first so it wins an address collision with w0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG && i == 0)) begin
               if (w1_en && w1_addr == ADDR_WIDTH'(i)) begin
                  r_regs[i] <= w1_data;
               end else if (w0_en && w0_addr == ADDR_WIDTH'(i)) begin
                  r_regs[i] <= w0_data;
               end
            end
         end
      end
   end

   assign reg0 = r_regs[0];

   always_comb begin
      logic [ADDR_WIDTH-1:0] w_idx;
      logic                  w_zeroHit;
      w_idx     = '0;
      w_zeroHit = 1'b0;
      rdata     = '0;
      rbusy     = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         w_idx     = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
         w_zeroHit = ZERO_REG && (w_idx == '0);
         if (!rst && !w_zeroHit) begin
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_idx];
            rbusy[k]                          = w_busy[w_idx];
`ifdef RF_BYPASS_EN
            // A same-cycle writeback overrides the array; a same-cycle issue keeps it busy.
            if ((w0_en && w0_addr == w_idx) || (w1_en && w1_addr == w_idx)) begin
               rdata[k*DATA_WIDTH +: DATA_WIDTH] =
                  (w1_en && w1_addr == w_idx) ? w1_data : w0_data;
               rbusy[k] = iss_valid && (iss_rd == w_idx);
            end
`endif
         end
      end
   end

endmodule
